// File: rtl/wb_gpio.sv
// Wishbone-classic GPIO slave: direction control, atomic set/clear, synchronised inputs
// and per-pin edge interrupts with a sticky W1C status register.
module wb_gpio #(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] RESET_OUT   = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [3:0]       wb_sel_i,
    input  logic [31:0]      wb_dat_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [WIDTH-1:0] gpio_i,
    output logic [WIDTH-1:0] gpio_o,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq_o
);

    localparam logic [2:0] AdrOut    = 3'd0;
    localparam logic [2:0] AdrOe     = 3'd1;
    localparam logic [2:0] AdrIn     = 3'd2;
    localparam logic [2:0] AdrRiseEn = 3'd3;
    localparam logic [2:0] AdrFallEn = 3'd4;
    localparam logic [2:0] AdrStatus = 3'd5;
    localparam logic [2:0] AdrOutSet = 3'd6;
    localparam logic [2:0] AdrOutClr = 3'd7;

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic             ack_q, ack_d;
    logic [31:0]      dat_q, dat_d;

    logic             req;
    logic [2:0]       reg_idx;
    logic [31:0]      lane_mask;
    logic [WIDTH-1:0] wmask, wdata, w1c, syn, rise, fall;
    logic [31:0]      rd;
    logic             unused_bits;

    assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i, lane_mask};

    assign reg_idx   = wb_adr_i[4:2];
    assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}}, {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};
    assign wmask     = lane_mask[WIDTH-1:0];
    // Unselected lanes behave as zero data for every write flavour.
    assign wdata     = wb_dat_i[WIDTH-1:0] & wmask;

    // The forced idle cycle after each ack keeps one request from being taken twice.
    assign req = wb_cyc_i & wb_stb_i & ~ack_q;

    assign syn  = sync_q[SYNC_STAGES-1];
    assign rise = syn & ~prev_q & rise_en_q;
    assign fall = ~syn & prev_q & fall_en_q;

    always_comb begin
        for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_d[i] = (i == 0) ? gpio_i : sync_q[(i == 0) ? 0 : i - 1];
        end
        prev_d = syn;
    end

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        rd        = '0;
        dat_d     = '0;
        ack_d     = req;

        if (req && wb_we_i) begin
            case (reg_idx)
                AdrOut:    out_d     = (out_q & ~wmask) | wdata;
                AdrOe:     oe_d      = (oe_q & ~wmask) | wdata;
                AdrRiseEn: rise_en_d = (rise_en_q & ~wmask) | wdata;
                AdrFallEn: fall_en_d = (fall_en_q & ~wmask) | wdata;
                AdrStatus: w1c       = wdata;
                AdrOutSet: out_d     = out_q | wdata;
                AdrOutClr: out_d     = out_q & ~wdata;
                default:   ;
            endcase
        end

        if (req && !wb_we_i) begin
            case (reg_idx)
                AdrOut:    rd[WIDTH-1:0] = out_q;
                AdrOe:     rd[WIDTH-1:0] = oe_q;
                AdrIn:     rd[WIDTH-1:0] = syn;
                AdrRiseEn: rd[WIDTH-1:0] = rise_en_q;
                AdrFallEn: rd[WIDTH-1:0] = fall_en_q;
                AdrStatus: rd[WIDTH-1:0] = status_q;
                default:   rd            = '0;
            endcase
            dat_d = rd;
        end

        // New events override a coincident clear.
        status_d = (status_q & ~w1c) | rise | fall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_q     <= RESET_OUT;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            ack_q     <= 1'b0;
            dat_q     <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= prev_d;
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
        end
    end

    assign wb_ack_o = ack_q & wb_cyc_i & wb_stb_i;
    assign wb_dat_o = dat_q;
    assign gpio_o   = out_q;
    assign gpio_oe  = oe_q;
    assign irq_o    = |status_q;

endmodule

// File: tb/tb_wb_gpio.sv
// Scoreboard bench for wb_gpio (WIDTH=32, SYNC_STAGES=3, RESET_OUT=0xA5).
module tb_wb_gpio;

    localparam int unsigned W = 32;

    localparam logic [2:0] RegOut    = 3'd0;
    localparam logic [2:0] RegOe     = 3'd1;
    localparam logic [2:0] RegIn     = 3'd2;
    localparam logic [2:0] RegRiseEn = 3'd3;
    localparam logic [2:0] RegFallEn = 3'd4;
    localparam logic [2:0] RegStatus = 3'd5;
    localparam logic [2:0] RegOutSet = 3'd6;
    localparam logic [2:0] RegOutClr = 3'd7;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_cyc_i, wb_stb_i, wb_we_i;
    logic [31:0]   wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]    wb_sel_i;
    logic          wb_ack_o;
    logic [W-1:0]  gpio_i, gpio_o, gpio_oe;
    logic          irq_o;

    typedef struct {
        string       name;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    wb_gpio #(
        .WIDTH      (W),
        .SYNC_STAGES(3),
        .RESET_OUT  (32'h0000_00A5)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .wb_cyc_i(wb_cyc_i),
        .wb_stb_i(wb_stb_i),
        .wb_we_i (wb_we_i),
        .wb_adr_i(wb_adr_i),
        .wb_sel_i(wb_sel_i),
        .wb_dat_i(wb_dat_i),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack_o),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq_o   (irq_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read acknowledge pops one expectation.
    always @(negedge clk) begin
        if (wb_ack_o === 1'b1 && wb_we_i === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected read ack: data %h, no expectation queued", wb_dat_o);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check(e.name, wb_dat_o, e.val);
            end
        end
    end

    task automatic wb_xfer(input string name, input logic we, input logic [2:0] idx,
                           input logic [3:0] sel, input logic [31:0] dat,
                           input logic [31:0] exp);
        int n;
        if (!we) exp_q.push_back('{name, exp});
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = {27'h0, idx, 2'b00};
        wb_sel_i = sel;
        wb_dat_i = dat;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (wb_ack_o !== 1'b1 && n < 8);
        if (wb_ack_o !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s ack timeout: got no ack, expected ack within 1 cycle", name);
            if (!we && exp_q.size() > 0) void'(exp_q.pop_back());
        end else begin
            check({name, " ack latency"}, n, 1);
            @(posedge clk);
            #1;
            check({name, " ack width"}, {31'h0, wb_ack_o}, 0);
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'h0;
        wb_dat_i = '0;
    endtask

    task automatic wr(input string name, input logic [2:0] idx, input logic [3:0] sel,
                      input logic [31:0] dat);
        wb_xfer(name, 1'b1, idx, sel, dat, 32'h0);
    endtask

    task automatic rd(input string name, input logic [2:0] idx, input logic [31:0] exp);
        wb_xfer(name, 1'b0, idx, 4'hF, 32'h0, exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        reset    = 1'b1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_sel_i = '0;
        wb_dat_i = '0;
        gpio_i   = 32'h0000_0002;  // pin 1 held high through reset
        repeat (3) @(negedge clk);
        check("reset gpio_o", gpio_o, 32'hA5);
        check("reset ack", {31'h0, wb_ack_o}, 0);
        reset = 1'b0;
        repeat (6) @(negedge clk);
        check("post-reset gpio_o", gpio_o, 32'hA5);
        check("post-reset gpio_oe", gpio_oe, 0);
        check("post-reset irq", {31'h0, irq_o}, 0);
        rd("status after reset", RegStatus, 32'h0);

        // Set/clear: 0xA5 | 0x0F = 0xAF, & ~0x05 = 0xAA.
        wr("oe", RegOe, 4'hF, 32'hFF);
        check("gpio_oe", gpio_oe, 32'hFF);
        wr("out_set", RegOutSet, 4'hF, 32'h0F);
        check("gpio_o after set", gpio_o, 32'hAF);
        wr("out_clr", RegOutClr, 4'hF, 32'h05);
        check("gpio_o after clr", gpio_o, 32'hAA);
        rd("out readback", RegOut, 32'hAA);
        rd("oe readback", RegOe, 32'hFF);
        wr("out no lanes", RegOut, 4'h0, 32'hFFFF_FFFF);
        check("gpio_o no lanes", gpio_o, 32'hAA);
        rd("out_set reads 0", RegOutSet, 32'h0);

        // Rising edge on pin 0; pin 1 already high must not retro-fire.
        wr("rise_en", RegRiseEn, 4'hF, 32'h03);
        @(negedge clk);
        gpio_i[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("irq before status edge", {31'h0, irq_o}, 0);
        @(posedge clk);
        #1;
        check("irq at status edge", {31'h0, irq_o}, 1);
        rd("in after rise", RegIn, 32'h03);
        rd("status rise", RegStatus, 32'h01);
        wr("status w1c no lanes", RegStatus, 4'h0, 32'h01);
        check("irq kept", {31'h0, irq_o}, 1);
        wr("status w1c", RegStatus, 4'h1, 32'h01);
        check("irq cleared", {31'h0, irq_o}, 0);
        @(negedge clk);
        gpio_i[0] = 1'b0;
        repeat (6) @(negedge clk);
        rd("status after fall, fall disabled", RegStatus, 32'h0);

        // Falling edge on pin 7 coinciding with a W1C of bit 7.
        wr("fall_en", RegFallEn, 4'hF, 32'h80);
        @(negedge clk);
        gpio_i[7] = 1'b1;
        repeat (6) @(negedge clk);
        rd("status pin7 high", RegStatus, 32'h0);
        @(negedge clk);
        gpio_i[7] = 1'b0;
        repeat (3) @(posedge clk);
        wr("status w1c race", RegStatus, 4'hF, 32'h80);
        check("irq after race", {31'h0, irq_o}, 1);
        rd("status set wins", RegStatus, 32'h80);
        wr("status w1c 7", RegStatus, 4'hF, 32'h80);
        rd("status cleared 7", RegStatus, 32'h0);

        // Per-lane writes of the full word.
        wr("out lane0", RegOut, 4'b0001, 32'hDEAD_BEEF);
        wr("out lane1", RegOut, 4'b0010, 32'hDEAD_BEEF);
        wr("out lane2", RegOut, 4'b0100, 32'hDEAD_BEEF);
        wr("out lane3", RegOut, 4'b1000, 32'hDEAD_BEEF);
        rd("out lanes", RegOut, 32'hDEAD_BEEF);
        wr("out_clr lane2", RegOutClr, 4'b0100, 32'hFFFF_FFFF);
        check("gpio_o lane clr", gpio_o, 32'hDE00_BEEF);

        wr("rise_en off", RegRiseEn, 4'hF, 32'h0);
        wr("fall_en off", RegFallEn, 4'hF, 32'h0);
        gpio_i = 32'h1234_5678;
        repeat (6) @(negedge clk);
        rd("in pattern", RegIn, 32'h1234_5678);
        wr("in write ignored", RegIn, 4'hF, 32'h0);
        rd("in after write", RegIn, 32'h1234_5678);
        check("irq quiet", {31'h0, irq_o}, 0);

        // Reset landing in the ack cycle of an OE write.
        @(negedge clk);
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = {27'h0, RegOe, 2'b00};
        wb_sel_i = 4'hF;
        wb_dat_i = 32'h3C;
        @(posedge clk);
        #1;
        check("ack before reset", {31'h0, wb_ack_o}, 1);
        check("oe before reset", gpio_oe, 32'h3C);
        reset = 1'b1;
        #1;
        check("ack in reset", {31'h0, wb_ack_o}, 0);
        check("oe in reset", gpio_oe, 0);
        check("out in reset", gpio_o, 32'hA5);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        wr("oe after reset", RegOe, 4'hF, 32'h0F);
        check("gpio_oe after reset", gpio_oe, 32'h0F);
        rd("oe readback after reset", RegOe, 32'h0F);

        repeat (3) @(negedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
